// File: rtl/shim_align_fifo_pkg.sv
// Shared sizing helpers for the alignment shim and its per-channel lanes.
package shim_align_fifo_pkg;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int lw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a read/write pointer into a power-of-2 deep lane.
    function automatic int pw_of(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/shim_align_lane.sv
// One first-word-fall-through FIFO lane: the head is always visible and the count is registered.
module shim_align_lane
    import shim_align_fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int LW    = lw_of(DEPTH),
    localparam int PW    = pw_of(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             accept;
    logic             take;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so a full lane still accepts when popping.
    assign accept = push && (!full || pop) && !flush;
    assign take   = pop && !flush;
    assign drop   = push && full && !pop && !flush;

    assign head = mem[rd_ptr];

    // NOTE: control state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (take)   rd_ptr <= rd_ptr + 1'b1;
            case ({accept, take})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (accept) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/shim_align_fifo.sv
// Multi-channel alignment shim: one FWFT lane per channel, a vector is emitted only when
// every lane holds a sample, and all lanes pop together on the output handshake.
module shim_align_fifo
    import shim_align_fifo_pkg::*;
#(
    parameter  int NUM_INPUTS = 1,
    parameter  int WIDTH      = 8,
    parameter  int DEPTH      = 4,
    localparam int LW         = lw_of(DEPTH)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_INPUTS*WIDTH-1:0] VALUES_IN,
    input  logic [NUM_INPUTS-1:0]       VALIDS_IN,
    input  logic                        FLUSH,
    input  logic                        CLEAR_OVF,
    output logic [NUM_INPUTS*WIDTH-1:0] VALUES_OUT,
    output logic                        VALID_OUT,
    input  logic                        READY_IN,
    output logic [NUM_INPUTS-1:0]       OVERFLOW,
    output logic [NUM_INPUTS*LW-1:0]    LEVELS
);

    logic [NUM_INPUTS-1:0] lane_empty;
    logic [NUM_INPUTS-1:0] lane_full;
    logic [NUM_INPUTS-1:0] lane_drop;
    logic                  pop;

    // Alignment is implied: a vector exists only once every lane is non-empty.
    assign VALID_OUT = ~|lane_empty;
    assign pop       = VALID_OUT && READY_IN;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        shim_align_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .CLK   (CLK),
            .RST   (RST),
            .push  (VALIDS_IN[i]),
            .pop   (pop),
            .flush (FLUSH),
            .din   (VALUES_IN[i*WIDTH +: WIDTH]),
            .head  (VALUES_OUT[i*WIDTH +: WIDTH]),
            .count (LEVELS[i*LW +: LW]),
            .full  (lane_full[i]),
            .empty (lane_empty[i]),
            .drop  (lane_drop[i])
        );
    end

    // A fresh drop outranks a simultaneous clear; FLUSH leaves the sticky bits alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERFLOW <= '0;
        end else begin
            OVERFLOW <= (CLEAR_OVF ? '0 : OVERFLOW) | lane_drop;
        end
    end

endmodule
